rx_frame_feeder: RTL

- Input-side stage that sits directly upstream of the OFDM receiver top.
- Buffers a continuous I/Q sample stream from the ADC interface in a FIFO.
- Delivers the samples to the receiver as discrete frames of FLEN_I samples on a CYC/STB/ACK handshake.
- Inserts a programmable idle gap between frames, so the receiver sees the same framing the system-level bench produces.

---
 rtl/rx_frame_feeder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rx_frame_feeder.sv
// rx_frame_feeder: buffers a continuous ADC I/Q stream in a first-word-fall-through
// FIFO and hands it to the OFDM receiver as fixed-length frames on a CYC/STB/ACK
// handshake, with a programmable idle gap between frames.
module rx_frame_feeder #(
  parameter int AW       = 9,
  parameter int START_TH = 64,
  parameter int GAP_CYC  = 10
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          EN_I,
  input  logic [15:0]   FLEN_I,
  input  logic [15:0]   Q_CH_I,
  input  logic [15:0]   I_CH_I,
  input  logic          VALID_I,
  input  logic          CLR_I,
  output logic [15:0]   Q_CH_O,
  output logic [15:0]   I_CH_O,
  output logic          CYC_O,
  output logic          STB_O,
  input  logic          ACK_I,
  output logic          OVF_O,
  output logic [AW:0]   LEVEL_O,
  output logic [15:0]   FRM_CNT_O
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic [31:0]   head;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          ovf_set;

  state_t        state;
  state_t        state_next;
  logic [15:0]   flen_r;
  logic [15:0]   flen_next;
  logic [15:0]   samp_cnt;
  logic [15:0]   samp_next;
  logic [15:0]   gap_cnt;
  logic [15:0]   gap_next;
  logic [15:0]   frm_cnt;
  logic [15:0]   frm_next;
  logic          cyc_next;
  logic          stb_next;

  // The occupancy never exceeds 2**AW, so its top bit alone marks a full FIFO.
  assign full       = level[AW];
  assign empty      = (level == '0);
  assign rd_en      = STB_O & ACK_I;
  assign wr_en      = VALID_I & (~full | rd_en);
  assign ovf_set    = VALID_I & full & ~rd_en;
  assign level_next = level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};

  assign head      = mem[rd_ptr];
  assign I_CH_O    = empty ? 16'd0 : head[31:16];
  assign Q_CH_O    = empty ? 16'd0 : head[15:0];
  assign LEVEL_O   = level;
  assign FRM_CNT_O = frm_cnt;

  // Sample storage; the ADC cannot be stalled, so writes happen in every state.
  always_ff @(posedge CLK_I) begin
    if (wr_en) mem[wr_ptr] <= {I_CH_I, Q_CH_I};
  end

  // FIFO pointers, occupancy and the sticky overflow flag (a new overflow beats a clear).
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      OVF_O  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      if (ovf_set)    OVF_O <= 1'b1;
      else if (CLR_I) OVF_O <= 1'b0;
    end
  end

  // Frame sequencer state and registered handshake outputs.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= IDLE;
      flen_r   <= '0;
      samp_cnt <= '0;
      gap_cnt  <= '0;
      frm_cnt  <= '0;
      CYC_O    <= 1'b0;
      STB_O    <= 1'b0;
    end else begin
      state    <= state_next;
      flen_r   <= flen_next;
      samp_cnt <= samp_next;
      gap_cnt  <= gap_next;
      frm_cnt  <= frm_next;
      CYC_O    <= cyc_next;
      STB_O    <= stb_next;
    end
  end

  // Next-state logic; STB is predicted from next-cycle occupancy so it tracks non-empty exactly.
  always_comb begin
    state_next = state;
    flen_next  = flen_r;
    samp_next  = samp_cnt;
    gap_next   = gap_cnt;
    frm_next   = frm_cnt;
    cyc_next   = 1'b0;
    stb_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN_I && (FLEN_I != 16'd0) && (int'(level) >= START_TH)) begin
          state_next = BURST;
          flen_next  = FLEN_I;
          samp_next  = '0;
          cyc_next   = 1'b1;
          stb_next   = (level_next != '0);
        end
      end
      BURST: begin
        cyc_next = 1'b1;
        stb_next = (level_next != '0);
        if (rd_en) begin
          if (samp_cnt == flen_r - 16'd1) begin
            frm_next   = frm_cnt + 16'd1;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            gap_next   = 16'd1;
            // The IDLE cycle itself counts as one gap cycle, so short gaps skip GAP.
            state_next = (GAP_CYC <= 1) ? IDLE : GAP;
          end else begin
            samp_next = samp_cnt + 16'd1;
          end
        end
      end
      GAP: begin
        if (int'(gap_cnt) >= GAP_CYC - 1) state_next = IDLE;
        else gap_next = gap_cnt + 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
